// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the 5-stage MIPS core.
// Carries a packed payload plus hazard fields (valid, regwe, a3, tnew, pc).
// Supports stall (hold), flush (bubble insert), optional Tnew decrement on load,
// a forwarding-ready flag and a saturating bubble counter for performance debug.
module pipe_stage_reg #(
    parameter int          DATA_W        = 32,
    parameter int          A3_W          = 5,
    parameter int          TNEW_W        = 2,
    parameter bit          DEC_TNEW      = 1'b1,
    parameter bit          KEEP_PC_FLUSH = 1'b1,
    parameter logic [31:0] PC_RST        = 32'h3000,
    parameter int          CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active low
    input  logic              en,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic              in_regwe,
    input  logic [A3_W-1:0]   in_a3,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_regwe,
    output logic [A3_W-1:0]   out_a3,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              fwd_ok,
    output logic [CNT_W-1:0]  bub_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_q,  valid_d;
    logic              regwe_q,  regwe_d;
    logic [A3_W-1:0]   a3_q,     a3_d;
    logic [TNEW_W-1:0] tnew_q,   tnew_d;
    logic [31:0]       pc_q,     pc_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [TNEW_W-1:0] tnew_load;
    logic [31:0]       pc_bubble;
    logic              bubble;

    // Tnew seen by the next stage: one cycle closer to ready, never below zero
    generate
        if (DEC_TNEW) begin : g_dec_tnew
            assign tnew_load = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
        end else begin : g_copy_tnew
            assign tnew_load = in_tnew;
        end
    endgenerate

    // A bubble may keep the incoming pc so CP0 can still report a sensible EPC
    generate
        if (KEEP_PC_FLUSH) begin : g_keep_pc
            assign pc_bubble = in_pc;
        end else begin : g_rst_pc
            assign pc_bubble = PC_RST;
        end
    endgenerate

    // Next-state selection: flush beats stall, stall beats load
    always_comb begin
        valid_d = valid_q;
        regwe_d = regwe_q;
        a3_d    = a3_q;
        tnew_d  = tnew_q;
        pc_d    = pc_q;
        data_d  = data_q;
        bubble  = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            regwe_d = 1'b0;
            a3_d    = '0;
            tnew_d  = '0;
            pc_d    = pc_bubble;
            data_d  = '0;
            bubble  = 1'b1;
        end else if (en) begin
            valid_d = in_valid;
            // an empty slot must never look like a pending GRF write
            regwe_d = in_valid & in_regwe;
            a3_d    = in_valid ? in_a3 : '0;
            tnew_d  = tnew_load;
            pc_d    = in_pc;
            data_d  = in_data;
            bubble  = ~in_valid;
        end
    end

    // Bubble counter: clear wins, otherwise count bubbles and stick at max
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (bubble && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pipeline state registers with asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            regwe_q <= 1'b0;
            a3_q    <= '0;
            tnew_q  <= '0;
            pc_q    <= PC_RST;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            regwe_q <= regwe_d;
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_regwe = regwe_q;
    assign out_a3    = a3_q;
    assign out_tnew  = tnew_q;
    assign out_pc    = pc_q;
    assign out_data  = data_q;
    assign bub_cnt   = cnt_q;
    assign fwd_ok    = valid_q & regwe_q & (a3_q != '0) & (tnew_q == '0);

endmodule
